thread_issue_scheduler: RTL and testbench

Per-thread issue stage directly downstream of the per-thread instruction buffers. Each cycle it selects at most one thread whose head instruction is valid and free of register hazards, using round-robin order. It dequeues that instruction and registers it toward operand fetch. A per-thread register scoreboard tracks in-flight destinations and is released by writeback.

---
 rtl/thread_issue_scheduler_if.sv | 84 ++++++++
 rtl/thread_issue_scheduler.sv | 140 ++++++++++++++
 tb/tb_thread_issue_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/thread_issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// thread_issue_scheduler_pkg / thread_issue_scheduler_if
//
// Purpose: shared types and the grouped port bundle between the per-thread
// instruction buffers, the issue scheduler and operand fetch.
//
// Package:
//   thread_id_t            - hardware thread index
//   reg_addr_t             - register index (vector/scalar select folded in)
//   instruction_decoded_t  - decoded head instruction; the scheduler only
//                            inspects the source/destination fields
//
// Interface signals (direction given for the slave = scheduler side):
//   in  enable                  global issue enable
//   in  thread_en[N]            per-thread run mask
//   in  ib_instructions_valid[N]
//   in  ib_instructions[N]      head instruction per thread
//   in  downstream_stall        operand fetch cannot accept
//   in  rb_valid[N]             per-thread rollback
//   in  wb_valid, wb_thread_id, wb_reg   scoreboard release
//   out is_thread_scheduled_mask[N]      combinational dequeue, one-hot or 0
//   out is_instr_valid, is_instr, is_thread_id   registered issue
// -----------------------------------------------------------------------------
`ifndef THREAD_NUMB
`define THREAD_NUMB 8
`endif

package thread_issue_scheduler_pkg;

  localparam int THREAD_NUMB = `THREAD_NUMB;
  localparam int THREAD_ID_W = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;
  localparam int REG_ADDR_W  = 6;

  typedef logic [THREAD_ID_W-1:0] thread_id_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op_code;
    reg_addr_t   source0;
    logic        is_source0;
    reg_addr_t   source1;
    logic        is_source1;
    reg_addr_t   destination;
    logic        has_destination;
  } instruction_decoded_t;

endpackage

interface thread_issue_scheduler_if #(
  parameter int THREAD_NUMB = thread_issue_scheduler_pkg::THREAD_NUMB,
  parameter int REG_ADDR_W  = thread_issue_scheduler_pkg::REG_ADDR_W
) ();

  logic                                                          enable;
  logic [THREAD_NUMB-1:0]                                        thread_en;
  logic [THREAD_NUMB-1:0]                                        ib_instructions_valid;
  thread_issue_scheduler_pkg::instruction_decoded_t [THREAD_NUMB-1:0] ib_instructions;
  logic                                                          downstream_stall;
  logic [THREAD_NUMB-1:0]                                        rb_valid;
  logic                                                          wb_valid;
  thread_issue_scheduler_pkg::thread_id_t                        wb_thread_id;
  logic [REG_ADDR_W-1:0]                                         wb_reg;

  logic [THREAD_NUMB-1:0]                                        is_thread_scheduled_mask;
  logic                                                          is_instr_valid;
  thread_issue_scheduler_pkg::instruction_decoded_t              is_instr;
  thread_issue_scheduler_pkg::thread_id_t                        is_thread_id;

  // Upstream/downstream environment side.
  modport master (
    output enable, thread_en, ib_instructions_valid, ib_instructions,
           downstream_stall, rb_valid, wb_valid, wb_thread_id, wb_reg,
    input  is_thread_scheduled_mask, is_instr_valid, is_instr, is_thread_id
  );

  // Scheduler side.
  modport slave (
    input  enable, thread_en, ib_instructions_valid, ib_instructions,
           downstream_stall, rb_valid, wb_valid, wb_thread_id, wb_reg,
    output is_thread_scheduled_mask, is_instr_valid, is_instr, is_thread_id
  );

endinterface

// File: rtl/thread_issue_scheduler.sv
// -----------------------------------------------------------------------------
// thread_issue_scheduler
//
// Purpose: picks at most one thread per cycle whose head instruction is valid,
// runnable and hazard-free, in round-robin order starting after the last
// granted thread. The grant dequeues the head combinationally and registers it
// toward operand fetch. A per-thread scoreboard marks in-flight destination
// registers; writeback releases them.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   sched  thread_issue_scheduler_if.slave  (see interface header)
// -----------------------------------------------------------------------------
`ifndef THREAD_NUMB
`define THREAD_NUMB 8
`endif

module thread_issue_scheduler
  import thread_issue_scheduler_pkg::*;
#(
  parameter int THREAD_NUMB = `THREAD_NUMB,
  parameter int REG_ADDR_W  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  thread_issue_scheduler_if.slave       sched
);

  localparam int SB_W = 1 << REG_ADDR_W;

  logic [SB_W-1:0]        r_scoreboard [THREAD_NUMB];
  thread_id_t             r_last_grant;
  logic                   r_instr_valid;
  instruction_decoded_t   r_instr;
  thread_id_t             r_thread_id;

  logic                   w_issue_ok;
  logic [THREAD_NUMB-1:0] w_eligible;
  logic                   w_grant_valid;
  thread_id_t             w_grant_id;
  logic [THREAD_NUMB-1:0] w_grant_mask;
  instruction_decoded_t   w_grant_instr;
  logic [REG_ADDR_W-1:0]  w_grant_dst;

  // A used source that is still in flight (RAW), or a destination that is
  // still in flight (WAW), holds the thread back.
  function automatic logic has_hazard(input logic [SB_W-1:0]    sb,
                                      input instruction_decoded_t ins);
    return (ins.is_source0      && sb[ins.source0[REG_ADDR_W-1:0]]) ||
           (ins.is_source1      && sb[ins.source1[REG_ADDR_W-1:0]]) ||
           (ins.has_destination && sb[ins.destination[REG_ADDR_W-1:0]]);
  endfunction

  // Thread index 'offset' positions after 'base', wrapping at THREAD_NUMB.
  function automatic thread_id_t rr_index(input thread_id_t base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= THREAD_NUMB) sum = sum - THREAD_NUMB;
    return thread_id_t'(sum);
  endfunction

  // Reset is folded in so the dequeue mask is quiet while reset is held.
  assign w_issue_ok = sched.enable & ~sched.downstream_stall & ~reset;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_eligible = '0;
    for (int t = 0; t < THREAD_NUMB; t++) begin
      w_eligible[t] = w_issue_ok
                    & sched.ib_instructions_valid[t]
                    & sched.thread_en[t]
                    & ~sched.rb_valid[t]
                    & ~has_hazard(r_scoreboard[t], sched.ib_instructions[t]);
    end
  end

  // Round-robin: scan last_grant+1 .. last_grant+THREAD_NUMB, first hit wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    for (int i = 1; i <= THREAD_NUMB; i++) begin
      if (!w_grant_valid && w_eligible[rr_index(r_last_grant, i)]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = rr_index(r_last_grant, i);
      end
    end
  end

  always_comb begin
    w_grant_mask = '0;
    if (w_grant_valid) w_grant_mask[w_grant_id] = 1'b1;
  end

  assign w_grant_instr = sched.ib_instructions[w_grant_id];
  assign w_grant_dst   = w_grant_instr.destination[REG_ADDR_W-1:0];

  // Scoreboard: writeback clears, a new issue sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scoreboard is explicitly reset because a stale in-flight bit
      // would block its thread forever; most memories need no reset at all.
      for (int t = 0; t < THREAD_NUMB; t++) r_scoreboard[t] <= '0;
    end else begin
      if (sched.wb_valid) begin
        r_scoreboard[sched.wb_thread_id][sched.wb_reg] <= 1'b0;
      end
      // NOTE: non-blocking assignments to the same bit resolve to the last one
      // written, so placing the set after the clear makes a same-cycle issue
      // keep ownership of the register.
      if (w_grant_valid && w_grant_instr.has_destination) begin
        r_scoreboard[w_grant_id][w_grant_dst] <= 1'b1;
      end
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= thread_id_t'(THREAD_NUMB - 1);
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_thread_id   <= '0;
    end else begin
      r_instr_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_last_grant <= w_grant_id;
        r_instr      <= w_grant_instr;
        r_thread_id  <= w_grant_id;
      end
    end
  end

  assign sched.is_thread_scheduled_mask = w_grant_mask;
  assign sched.is_instr_valid           = r_instr_valid;
  assign sched.is_instr                 = r_instr;
  assign sched.is_thread_id             = r_thread_id;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_issue_scheduler
//
// Directed bench for thread_issue_scheduler with 8 threads. A table of
// per-cycle input/expected-output records exercises arbitration order, gating
// and pointer movement; hand-written sequences cover scoreboard hazards,
// writeback timing, same-cycle set/clear and mid-stream reset.
// Inputs change 1 time unit after the rising edge; the combinational mask is
// sampled 2 units later and registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_thread_issue_scheduler;
  import thread_issue_scheduler_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  thread_issue_scheduler_if #(.THREAD_NUMB(N), .REG_ADDR_W(6)) sif ();

  thread_issue_scheduler #(.THREAD_NUMB(N), .REG_ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (sif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every thread's instruction carries pc = 0x100 + thread so the registered
  // instruction identifies which head was captured.
  function automatic instruction_decoded_t mk_instr(input int t,
      input int s0, input logic is0, input int s1, input logic is1,
      input int d, input logic hd);
    instruction_decoded_t r;
    r.pc              = 32'h100 + 32'(t);
    r.op_code         = 8'(t);
    r.source0         = reg_addr_t'(s0);
    r.is_source0      = is0;
    r.source1         = reg_addr_t'(s1);
    r.is_source1      = is1;
    r.destination     = reg_addr_t'(d);
    r.has_destination = hd;
    return r;
  endfunction

  task automatic plain_heads();
    for (int t = 0; t < N; t++) sif.ib_instructions[t] = mk_instr(t, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic drive(input logic [7:0] valid, input logic [7:0] en, input logic [7:0] rb,
                       input logic enable, input logic stall);
    sif.ib_instructions_valid = valid;
    sif.thread_en             = en;
    sif.rb_valid              = rb;
    sif.enable                = enable;
    sif.downstream_stall      = stall;
  endtask

  // One cycle: check the dequeue mask mid-cycle, clock, check registered issue.
  task automatic cycle(input string name, input logic [7:0] exp_mask,
                       input logic exp_valid, input int exp_tid);
    #2;
    check({name, " mask"}, 64'(sif.is_thread_scheduled_mask), 64'(exp_mask));
    @(posedge clk);
    #1;
    check({name, " valid"}, 64'(sif.is_instr_valid), 64'(exp_valid));
    check({name, " tid"}, 64'(sif.is_thread_id), 64'(exp_tid));
    check({name, " pc"}, 64'(sif.is_instr.pc), 64'(32'h100 + 32'(exp_tid)));
  endtask

  task automatic wb(input logic v, input int tid, input int r);
    sif.wb_valid     = v;
    sif.wb_thread_id = thread_id_t'(tid);
    sif.wb_reg       = reg_addr_t'(r);
  endtask

  typedef struct {
    logic [7:0] valid;
    logic [7:0] en;
    logic [7:0] rb;
    logic       enable;
    logic       stall;
    logic [7:0] exp_mask;
    logic       exp_valid;
    int         exp_tid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [7:0] valid, input logic [7:0] en, input logic [7:0] rb,
                             input logic enable, input logic stall,
                             input logic [7:0] exp_mask, input logic exp_valid, input int exp_tid);
    vec_t r;
    r = '{valid, en, rb, enable, stall, exp_mask, exp_valid, exp_tid};
    return r;
  endfunction

  initial begin
    // Pointer starts at 7: thread 0 has first priority after reset.
    for (int t = 0; t < N; t++) vecs.push_back(v(8'hFF, 8'hFF, 8'h00, 1, 0, 8'(1 << t), 1, t));
    vecs.push_back(v(8'hFF, 8'hFF, 8'h00, 1, 0, 8'h01, 1, 0));      // wrap back to 0
    for (int k = 0; k < 3; k++)                                      // stall: no dequeue, hold
      vecs.push_back(v(8'h0F, 8'hFF, 8'h00, 1, 1, 8'h00, 0, 0));
    vecs.push_back(v(8'h0F, 8'hFF, 8'h00, 1, 0, 8'h02, 1, 1));      // resumes at last+1
    vecs.push_back(v(8'h0F, 8'hFF, 8'h00, 1, 0, 8'h04, 1, 2));
    vecs.push_back(v(8'h0F, 8'hFF, 8'h00, 1, 0, 8'h08, 1, 3));
    vecs.push_back(v(8'h0F, 8'hFF, 8'h00, 1, 0, 8'h01, 1, 0));
    vecs.push_back(v(8'hFF, 8'hFF, 8'h00, 0, 0, 8'h00, 0, 0));      // global enable off
    vecs.push_back(v(8'hFF, 8'h10, 8'h00, 1, 0, 8'h10, 1, 4));      // run mask
    vecs.push_back(v(8'h02, 8'hFF, 8'h00, 1, 0, 8'h02, 1, 1));      // last=1
    vecs.push_back(v(8'h0A, 8'hFF, 8'h00, 1, 0, 8'h08, 1, 3));      // 1,3 valid -> 3
    vecs.push_back(v(8'h02, 8'hFF, 8'h00, 1, 0, 8'h02, 1, 1));      // 3 empty -> 1
    vecs.push_back(v(8'h0A, 8'hFF, 8'h00, 1, 0, 8'h08, 1, 3));
    vecs.push_back(v(8'h20, 8'hFF, 8'h20, 1, 0, 8'h00, 0, 3));      // rollback blocks 5
    vecs.push_back(v(8'h20, 8'hFF, 8'h00, 1, 0, 8'h20, 1, 5));
    vecs.push_back(v(8'h60, 8'hFF, 8'h20, 1, 0, 8'h40, 1, 6));      // rollback 5 -> 6
    vecs.push_back(v(8'h81, 8'hFF, 8'h00, 1, 0, 8'h80, 1, 7));
    vecs.push_back(v(8'h81, 8'hFF, 8'h00, 1, 0, 8'h01, 1, 0));      // wrap 7 -> 0
    vecs.push_back(v(8'h00, 8'hFF, 8'h00, 1, 0, 8'h00, 0, 0));

    // Reset state, with every thread requesting.
    reset = 1'b1;
    plain_heads();
    wb(1'b0, 0, 0);
    drive(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("reset mask", 64'(sif.is_thread_scheduled_mask), 64'h0);
    check("reset valid", 64'(sif.is_instr_valid), 64'h0);
    check("reset tid", 64'(sif.is_thread_id), 64'h0);
    check("reset instr", 64'(sif.is_instr), 64'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].en, vecs[i].rb, vecs[i].enable, vecs[i].stall);
      cycle($sformatf("row%0d", i), vecs[i].exp_mask, vecs[i].exp_valid, vecs[i].exp_tid);
    end

    // RAW hazard on thread 2, released by writeback without bypass. last=0.
    sif.ib_instructions[2] = mk_instr(2, 0, 1'b0, 0, 1'b0, 5, 1'b1);
    drive(8'h04, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle("raw issue", 8'h04, 1'b1, 2);
    check("raw dest", 64'(sif.is_instr.destination), 64'd5);
    sif.ib_instructions[2] = mk_instr(2, 5, 1'b1, 0, 1'b0, 0, 1'b0);
    cycle("raw blocked0", 8'h00, 1'b0, 2);
    cycle("raw blocked1", 8'h00, 1'b0, 2);
    wb(1'b1, 2, 5);
    cycle("raw wb cycle", 8'h00, 1'b0, 2);
    wb(1'b0, 0, 0);
    cycle("raw released", 8'h04, 1'b1, 2);
    check("raw src0", 64'(sif.is_instr.source0), 64'd5);

    // Same-cycle clear and set on thread 4 r9: set must win. last=2.
    sif.ib_instructions[4] = mk_instr(4, 0, 1'b0, 0, 1'b0, 9, 1'b1);
    drive(8'h10, 8'hFF, 8'h00, 1'b1, 1'b0);
    wb(1'b1, 4, 9);
    cycle("setclr issue", 8'h10, 1'b1, 4);
    wb(1'b0, 0, 0);
    sif.ib_instructions[4] = mk_instr(4, 9, 1'b1, 0, 1'b0, 0, 1'b0);
    cycle("setclr read blocked", 8'h00, 1'b0, 4);
    sif.ib_instructions[4] = mk_instr(4, 0, 1'b0, 0, 1'b0, 9, 1'b1);
    wb(1'b1, 3, 9);                                  // other thread's release
    cycle("waw blocked", 8'h00, 1'b0, 4);
    wb(1'b1, 4, 9);
    cycle("waw wb cycle", 8'h00, 1'b0, 4);
    wb(1'b0, 0, 0);
    cycle("waw released", 8'h10, 1'b1, 4);

    // Sole eligible thread issues back-to-back. last=4.
    drive(8'h40, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle("b2b first", 8'h40, 1'b1, 6);
    cycle("b2b second", 8'h40, 1'b1, 6);

    // Build a pending hazard on thread 1, then reset mid-stream. last=6.
    sif.ib_instructions[1] = mk_instr(1, 0, 1'b0, 0, 1'b0, 3, 1'b1);
    drive(8'h02, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle("rst pre issue", 8'h02, 1'b1, 1);
    sif.ib_instructions[1] = mk_instr(1, 0, 1'b0, 3, 1'b1, 0, 1'b0);
    cycle("rst pre blocked", 8'h00, 1'b0, 1);
    drive(8'h43, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle("rst pre grant6", 8'h40, 1'b1, 6);
    reset = 1'b1;
    #1;
    check("midrst mask", 64'(sif.is_thread_scheduled_mask), 64'h0);
    check("midrst valid", 64'(sif.is_instr_valid), 64'h0);
    check("midrst tid", 64'(sif.is_thread_id), 64'h0);
    check("midrst instr", 64'(sif.is_instr), 64'h0);
    @(posedge clk);
    #1;
    check("midrst held valid", 64'(sif.is_instr_valid), 64'h0);
    reset = 1'b0;
    drive(8'h03, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle("postrst grant0", 8'h01, 1'b1, 0);
    cycle("postrst sb clear", 8'h02, 1'b1, 1);
    check("postrst src1", 64'(sif.is_instr.source1), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
